// File: rtl/bus_pkg.sv
// Shared bus definitions: transfer mode encoding, responder state encoding
// and wait-counter width.
package bus_pkg;

   localparam logic BUS_MODE_READ  = 1'b0;
   localparam logic BUS_MODE_WRITE = 1'b1;

   localparam int WCNT_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_ACCESS,
      ST_RESP
   } bus_state_t;

endpackage

// File: rtl/bus_mem_responder_if.sv
// CPU bus between the control unit (master) and the memory responder (slave).
// BUS_err exists only when BUS_ALIGN_ERR_EN is defined.
interface bus_mem_responder_if;

   logic        BUS_start_transaction;
   logic        BUS_mode;
   logic [31:0] BUS_addr;
   logic [31:0] BUS_wdata;
   logic [31:0] BUS_rdata;
   logic        BUS_rdata_valid;
   logic        BUS_write_done;
`ifdef BUS_ALIGN_ERR_EN
   logic        BUS_err;
`endif

   modport master (
      output BUS_start_transaction, BUS_mode, BUS_addr, BUS_wdata,
`ifdef BUS_ALIGN_ERR_EN
      input  BUS_err,
`endif
      input  BUS_rdata, BUS_rdata_valid, BUS_write_done
   );

   modport slave (
      input  BUS_start_transaction, BUS_mode, BUS_addr, BUS_wdata,
`ifdef BUS_ALIGN_ERR_EN
      output BUS_err,
`endif
      output BUS_rdata, BUS_rdata_valid, BUS_write_done
   );

endinterface

// File: rtl/bus_mem_array.sv
// Single-port 2^DEPTH_LOG2 x 32 synchronous RAM with registered read
// (read-before-write). Contents are not reset.
module bus_mem_array #(
   parameter int DEPTH_LOG2 = 8
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [DEPTH_LOG2-1:0] addr,
   input  logic [31:0]           din,
   output logic [31:0]           dout
);

   logic [31:0] mem [0:(1<<DEPTH_LOG2)-1];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= din;
      end
      dout <= mem[addr];
   end

endmodule

// File: rtl/bus_mem_responder.sv
// Bus target: accepts one transaction, waits WAIT_CYCLES, then reads or writes
// the internal RAM and pulses a response. Optional feature: BUS_ALIGN_ERR_EN.
module bus_mem_responder
   import bus_pkg::*;
#(
   parameter int DEPTH_LOG2  = 8,
   parameter int WAIT_CYCLES = 2
) (
   input  logic          clk,
   input  logic          rst_n,
   bus_mem_responder_if.slave bus,
   output logic          busy
);

   localparam logic [WCNT_W-1:0] WAIT_LOAD =
      (WAIT_CYCLES == 0) ? '0 : WCNT_W'(WAIT_CYCLES - 1);

   bus_state_t            state_reg;
   logic [WCNT_W-1:0]     cnt_reg;
   logic [DEPTH_LOG2-1:0] idx_reg;
   logic [31:0]           wdata_reg;
   logic                  mode_reg;
   logic                  misalign_reg;
   logic [31:0]           rdata_reg;
   logic                  rdata_valid_reg;
   logic                  write_done_reg;
   logic                  busy_reg;
   logic [DEPTH_LOG2-1:0] ram_addr;
   logic [31:0]           ram_dout;
   logic                  ram_we;
   logic                  unused_addr_bits;

   assign unused_addr_bits = ^{bus.BUS_addr[31:DEPTH_LOG2+2], bus.BUS_addr[1:0]};

   // The RAM is addressed from the live bus while idle so the word is already
   // in dout by ACCESS, even when there are no wait states.
   assign ram_addr = (state_reg == ST_IDLE) ? bus.BUS_addr[DEPTH_LOG2+1:2] : idx_reg;
   assign ram_we   = (state_reg == ST_ACCESS) && (mode_reg == BUS_MODE_WRITE) && !misalign_reg;

   bus_mem_array #(.DEPTH_LOG2(DEPTH_LOG2)) u_mem (
      .clk  (clk),
      .we   (ram_we),
      .addr (ram_addr),
      .din  (wdata_reg),
      .dout (ram_dout)
   );

`ifdef BUS_ALIGN_ERR_EN
   logic err_reg;
   assign bus.BUS_err = err_reg;
`else
   assign misalign_reg = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg       <= ST_IDLE;
         cnt_reg         <= '0;
         idx_reg         <= '0;
         wdata_reg       <= '0;
         mode_reg        <= BUS_MODE_READ;
         rdata_reg       <= '0;
         rdata_valid_reg <= 1'b0;
         write_done_reg  <= 1'b0;
         busy_reg        <= 1'b0;
`ifdef BUS_ALIGN_ERR_EN
         misalign_reg    <= 1'b0;
         err_reg         <= 1'b0;
`endif
      end else begin
         rdata_valid_reg <= 1'b0;
         write_done_reg  <= 1'b0;
`ifdef BUS_ALIGN_ERR_EN
         err_reg         <= 1'b0;
`endif
         case (state_reg)
            ST_IDLE: begin
               if (bus.BUS_start_transaction) begin
                  idx_reg   <= bus.BUS_addr[DEPTH_LOG2+1:2];
                  wdata_reg <= bus.BUS_wdata;
                  mode_reg  <= bus.BUS_mode;
                  cnt_reg   <= WAIT_LOAD;
                  busy_reg  <= 1'b1;
                  state_reg <= (WAIT_CYCLES == 0) ? ST_ACCESS : ST_WAIT;
`ifdef BUS_ALIGN_ERR_EN
                  misalign_reg <= |bus.BUS_addr[1:0];
`endif
               end
            end
            ST_WAIT: begin
               if (cnt_reg == '0) begin
                  state_reg <= ST_ACCESS;
               end else begin
                  cnt_reg <= cnt_reg - 1'b1;
               end
            end
            ST_ACCESS: begin
               if (mode_reg == BUS_MODE_READ) begin
                  rdata_reg       <= misalign_reg ? 32'h0 : ram_dout;
                  rdata_valid_reg <= 1'b1;
               end else begin
                  write_done_reg  <= 1'b1;
               end
`ifdef BUS_ALIGN_ERR_EN
               err_reg   <= misalign_reg;
`endif
               state_reg <= ST_RESP;
            end
            default: begin
               busy_reg  <= 1'b0;
               state_reg <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.BUS_rdata       = rdata_reg;
   assign bus.BUS_rdata_valid = rdata_valid_reg;
   assign bus.BUS_write_done  = write_done_reg;
   assign busy                = busy_reg;

endmodule

// File: tb/tb_bus_mem_responder.sv
// Bench for bus_mem_responder: two instances (WAIT_CYCLES=2 and 0) checked
// against an array model of the memory; honours BUS_ALIGN_ERR_EN.
module tb_bus_mem_responder;
   import bus_pkg::*;

   localparam int DL_A = 8, W_A = 2;
   localparam int DL_B = 4, W_B = 0;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic        start_drv = 1'b0, mode_drv = 1'b0, sel_b = 1'b0;
   logic [31:0] addr_drv = '0, wdata_drv = '0;
   logic        busy_a, busy_b;

   bus_mem_responder_if bus_a ();
   bus_mem_responder_if bus_b ();

   assign bus_a.BUS_start_transaction = start_drv & ~sel_b;
   assign bus_b.BUS_start_transaction = start_drv & sel_b;
   assign bus_a.BUS_mode  = mode_drv;
   assign bus_b.BUS_mode  = mode_drv;
   assign bus_a.BUS_addr  = addr_drv;
   assign bus_b.BUS_addr  = addr_drv;
   assign bus_a.BUS_wdata = wdata_drv;
   assign bus_b.BUS_wdata = wdata_drv;

   bus_mem_responder #(.DEPTH_LOG2(DL_A), .WAIT_CYCLES(W_A)) dut_a (
      .clk(clk), .rst_n(rst_n), .bus(bus_a), .busy(busy_a));
   bus_mem_responder #(.DEPTH_LOG2(DL_B), .WAIT_CYCLES(W_B)) dut_b (
      .clk(clk), .rst_n(rst_n), .bus(bus_b), .busy(busy_b));

   logic        o_valid, o_done, o_busy;
   logic [31:0] o_rdata;
   logic        o_err;
   assign o_valid = sel_b ? bus_b.BUS_rdata_valid : bus_a.BUS_rdata_valid;
   assign o_done  = sel_b ? bus_b.BUS_write_done  : bus_a.BUS_write_done;
   assign o_rdata = sel_b ? bus_b.BUS_rdata       : bus_a.BUS_rdata;
   assign o_busy  = sel_b ? busy_b : busy_a;
`ifdef BUS_ALIGN_ERR_EN
   assign o_err   = sel_b ? bus_b.BUS_err : bus_a.BUS_err;
`else
   assign o_err   = 1'b0;
`endif

   logic [31:0] mem_a [256];
   logic [31:0] mem_b [16];
   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One bus transaction with latency, pulse and data checks against the model.
   task automatic txn(input bit b, input bit wr, input logic [31:0] a,
                      input logic [31:0] d, input bit hammer);
      int          lat_exp, idx, lat, pulses;
      bit          mis;
      logic [31:0] exp_rd;
      lat_exp = (b ? W_B : W_A) + 2;
      idx     = b ? int'((a / 4) % 16) : int'((a / 4) % 256);
      mis     = 1'b0;
`ifdef BUS_ALIGN_ERR_EN
      mis = (a % 4) != 0;
`endif
      exp_rd = mis ? 32'h0 : (b ? mem_b[idx] : mem_a[idx]);
      if (wr && !mis) begin
         if (b) mem_b[idx] = d;
         else   mem_a[idx] = d;
      end
      sel_b = b; start_drv = 1'b1; mode_drv = wr; addr_drv = a; wdata_drv = d;
      @(posedge clk);
      #1;
      if (hammer) begin
         mode_drv = BUS_MODE_WRITE; wdata_drv = ~d;
      end else begin
         start_drv = 1'b0; addr_drv = $urandom; wdata_drv = $urandom;
         mode_drv = 1'($urandom_range(0, 1));
      end
      lat = 0; pulses = 0;
      for (int c = 1; c <= lat_exp + 2; c++) begin
         @(negedge clk);
         if (o_valid || o_done) begin
            pulses++;
            if (lat == 0) begin
               lat = c;
               chk("rdata_valid", {31'b0, o_valid}, {31'b0, !wr});
               chk("write_done", {31'b0, o_done}, {31'b0, wr});
               chk("err", {31'b0, o_err}, {31'b0, mis});
               if (!wr) chk("rdata", o_rdata, exp_rd);
            end
         end
         if (c <= lat_exp) chk("busy_high", {31'b0, o_busy}, 32'd1);
         if (c == lat_exp) start_drv = 1'b0;
      end
      chk("latency", lat, lat_exp);
      chk("pulse_count", pulses, 1);
      chk("busy_low", {31'b0, o_busy}, 32'd0);
      if (!wr) chk("rdata_held", o_rdata, exp_rd);
      $display("txn inst=%0d %s addr=%h data=%h lat=%0d", b, wr ? "WR" : "RD", a,
               wr ? d : o_rdata, lat);
   endtask

   initial begin
      logic [31:0] prior;
      int          dones;
      repeat (2) @(negedge clk);
      chk("rst_busy", {31'b0, busy_a}, 32'd0);
      chk("rst_valid", {31'b0, bus_a.BUS_rdata_valid}, 32'd0);
      chk("rst_done", {31'b0, bus_a.BUS_write_done}, 32'd0);
      chk("rst_rdata", bus_a.BUS_rdata, 32'd0);
      chk("rst_err", {31'b0, o_err}, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 256; i++) txn(1'b0, 1'b1, 32'(i * 4), $urandom, 1'b0);
      for (int i = 0; i < 16; i++)  txn(1'b1, 1'b1, 32'(i * 4), $urandom, 1'b0);

      txn(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0);
      txn(1'b0, 1'b0, 32'h10, 32'h0, 1'b0);
      txn(1'b1, 1'b1, 32'h04, 32'hCAFEF00D, 1'b0);
      txn(1'b1, 1'b0, 32'h04, 32'h0, 1'b0);
      txn(1'b0, 1'b1, 32'h400, 32'h1234, 1'b0);
      txn(1'b0, 1'b0, 32'h000, 32'h0, 1'b0);
      txn(1'b0, 1'b1, 32'h30, 32'hA5A5A5A5, 1'b1);
      txn(1'b0, 1'b0, 32'h30, 32'h0, 1'b0);

      // Reset lands in WAIT of a write to 0x20: the write must be discarded.
      prior = mem_a[8];
      sel_b = 1'b0; start_drv = 1'b1; mode_drv = BUS_MODE_WRITE;
      addr_drv = 32'h20; wdata_drv = ~prior;
      @(posedge clk);
      #1 start_drv = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("midrst_busy", {31'b0, busy_a}, 32'd0);
      chk("midrst_valid", {31'b0, bus_a.BUS_rdata_valid}, 32'd0);
      chk("midrst_done", {31'b0, bus_a.BUS_write_done}, 32'd0);
      chk("midrst_rdata", bus_a.BUS_rdata, 32'd0);
      chk("midrst_err", {31'b0, o_err}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      dones = 0;
      repeat (6) begin
         @(negedge clk);
         if (bus_a.BUS_write_done) dones++;
      end
      chk("midrst_no_done", dones, 0);
      txn(1'b0, 1'b0, 32'h20, 32'h0, 1'b0);

      txn(1'b0, 1'b1, 32'h22, 32'h55AA55AA, 1'b0);
      txn(1'b0, 1'b0, 32'h20, 32'h0, 1'b0);
      txn(1'b0, 1'b0, 32'h21, 32'h0, 1'b0);

      for (int i = 0; i < 80; i++)
         txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, $urandom, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
